// File: rtl/systolic_gemm_engine.sv
// Output-stationary ROWS x COLS int8 systolic GEMM engine with internal operand skewing,
// a valid bit carried through the mesh, and a clear/feed/flush/drain control FSM.
module systolic_gemm_engine #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OFF_W  = 9,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K_W    = 16,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    accumulate,
  input  logic [K_W-1:0]          k_len,
  input  logic [OFF_W-1:0]        input_offset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  ifmap_in,
  input  logic [COLS*DATA_W-1:0]  weight_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic [ROW_W-1:0]        out_row,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned SUM_W  = OFF_W + 1;
  localparam int unsigned PROD_W = SUM_W + DATA_W;
  localparam int unsigned FL_W   = (ROWS + COLS > 2) ? $clog2(ROWS + COLS) : 1;

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

  state_e            state_q;
  logic [K_W-1:0]    k_len_q, beat_cnt_q;
  logic [FL_W-1:0]   flush_cnt_q;
  logic [ROW_W-1:0]  row_q;
  logic [OFF_W-1:0]  off_q;
  logic              done_q;
  logic              accept, clear_acc;

  logic [DATA_W-1:0] a_h  [ROWS][COLS];
  logic              va_h [ROWS][COLS];
  logic [DATA_W-1:0] b_h  [ROWS][COLS];
  logic              vb_h [ROWS][COLS];
  logic [ACC_W-1:0]  acc_w [ROWS][COLS];

  assign in_ready  = (state_q == StFeed);
  assign out_valid = (state_q == StDrain);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_row   = row_q;
  assign accept    = in_valid & in_ready;
  assign clear_acc = (state_q == StIdle) && start && (k_len != '0) && !accumulate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      off_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (k_len != '0) begin
              k_len_q    <= k_len;
              off_q      <= input_offset;
              beat_cnt_q <= '0;
              state_q    <= StFeed;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StFeed: begin
          if (accept) begin
            if (beat_cnt_q == k_len_q - 1'b1) begin
              flush_cnt_q <= '0;
              state_q     <= StFlush;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        StFlush: begin
          // Wait until the last injected beat has reached PE(ROWS-1, COLS-1).
          if (flush_cnt_q == FL_W'(ROWS + COLS - 2)) begin
            row_q   <= '0;
            state_q <= StDrain;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (row_q == ROW_W'(ROWS - 1)) begin
              row_q   <= '0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ifmap lane r sits behind r+1 registers, weight lane c behind c+1 registers.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
    logic [DATA_W-1:0] d_q [r+1];
    logic              v_q [r+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        d_q[0] <= accept ? ifmap_in[r*DATA_W +: DATA_W] : '0;
        v_q[0] <= accept;
        for (int i = 1; i <= r; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end
    assign a_h[r][0]  = d_q[r];
    assign va_h[r][0] = v_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_skew_b
    logic [DATA_W-1:0] d_q [c+1];
    logic              v_q [c+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= c; i++) begin
          d_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else begin
        d_q[0] <= accept ? weight_in[c*DATA_W +: DATA_W] : '0;
        v_q[0] <= accept;
        for (int i = 1; i <= c; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end
    assign b_h[0][c]  = d_q[c];
    assign vb_h[0][c] = v_q[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic [ACC_W-1:0]  acc_q;
      logic [SUM_W-1:0]  sum;
      logic [PROD_W-1:0] prod;

      assign sum  = {{(SUM_W-DATA_W){a_h[r][c][DATA_W-1]}}, a_h[r][c]}
                  + {{(SUM_W-OFF_W){off_q[OFF_W-1]}}, off_q};
      // Both operands sign-extended to PROD_W, so the truncated product is exact.
      assign prod = {{(PROD_W-SUM_W){sum[SUM_W-1]}}, sum}
                  * {{(PROD_W-DATA_W){b_h[r][c][DATA_W-1]}}, b_h[r][c]};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_q <= '0;
        end else if (clear_acc) begin
          acc_q <= '0;
        end else if (va_h[r][c] && vb_h[r][c]) begin
          acc_q <= acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
      end
      assign acc_w[r][c] = acc_q;

      if (c < COLS - 1) begin : g_right
        logic [DATA_W-1:0] a_q;
        logic              va_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_q  <= '0;
            va_q <= 1'b0;
          end else begin
            a_q  <= a_h[r][c];
            va_q <= va_h[r][c];
          end
        end
        assign a_h[r][c+1]  = a_q;
        assign va_h[r][c+1] = va_q;
      end

      if (r < ROWS - 1) begin : g_down
        logic [DATA_W-1:0] b_q;
        logic              vb_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            b_q  <= '0;
            vb_q <= 1'b0;
          end else begin
            b_q  <= b_h[r][c];
            vb_q <= vb_h[r][c];
          end
        end
        assign b_h[r+1][c]  = b_q;
        assign vb_h[r+1][c] = vb_q;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) begin
      out_data[c*ACC_W +: ACC_W] = acc_w[row_q][c];
    end
  end

endmodule

// File: doc/systolic_gemm_engine.md
# systolic_gemm_engine

Parametrised ROWS×COLS output-stationary int8 systolic GEMM engine with internal input/weight skewing, a valid bit carried through the PE mesh, and a control FSM that sequences clear, feed, flush and row-by-row drain. It replaces the fixed 4×4 array with an externally skewed, free-running interface. It sits between the operand buffers (ifmap/weight streams) and the output post-processing stage. It adds handshaked streams, stall tolerance and an accumulate-across-tiles mode.

## Interface
- ROWS, 4, number of PE rows; one ifmap lane per row.
- COLS, 4, number of PE columns; one weight lane per column.
- DATA_W, 8, signed ifmap/weight element width.
- OFF_W, 9, signed input_offset width.
- ACC_W, 32, signed accumulator width.
- K_W, 16, width of k_len.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- accumulate  in  1  sampled with start: 1 = keep accumulators, 0 = clear them.
- k_len  in  K_W  beats to accept, sampled with start.
- input_offset  in  OFF_W  signed, sampled with start, held internally.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat; high only in FEED.
- ifmap_in  in  ROWS*DATA_W  lane r at bits [r*DATA_W +: DATA_W], signed.
- weight_in  in  COLS*DATA_W  lane c at bits [c*DATA_W +: DATA_W], signed.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  downstream accepts a drain beat.
- out_data  out  COLS*ACC_W  accumulators of row out_row; column c at [c*ACC_W +: ACC_W].
- out_row  out  clog2(ROWS) (min 1)  row index of the current drain beat.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

## Operation
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE with start=1 and k_len≠0:
  - latch k_len and input_offset;
  - if accumulate=0, zero all accumulators;
  - go to FEED.
- IDLE with start=1 and k_len=0: no clear and no output; done pulses next cycle; state stays IDLE.
- FEED:
  - in_ready=1; a beat is accepted when in_valid&in_ready.
  - An accepted beat enters the skew network: ifmap lane r is delayed r cycles, weight lane c is delayed c cycles, both tagged valid=1.
  - A non-accepted cycle injects valid=0.
  - After k_len accepts, go to FLUSH.
- PE(r,c):
  - ifmap and valid pass right one register per column; weight and valid pass down one register per row.
  - When the valid bit is set: acc += (sext(ifmap)+sext(input_offset)) × sext(weight).
  - The operand sum is OFF_W+1 bits, the product 2·DATA_W+2 bits; both are sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- FLUSH: counts ROWS+COLS−1 cycles with bubbles injected, then goes to DRAIN.
- DRAIN:
  - Rows are emitted in order 0..ROWS−1, one beat per handshake (out_valid&out_ready).
  - out_data and out_row hold stable while out_valid=1 and out_ready=0.
  - After row ROWS−1 transfers, go to IDLE and pulse done.
- start is ignored whenever busy=1.
- in_valid in any state other than FEED is ignored and no beat is consumed.
- Reset at any point: state IDLE; all accumulators, skew registers and valid bits zero; latched offset zero.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_row=0, busy=0, done=0.
- Cycle of the start sample = cycle 0; FEED is active (in_ready=1) from cycle 1.
- Label the cycle that accepts beat k as cycle t_k:
  - PE(r,c) accumulates beat k at the clock edge ending cycle t_k+r+c+1;
  - the last PE (ROWS−1, COLS−1) finishes at t_last+ROWS+COLS−1.
- With the cycle accepting the last beat = cycle 0, FLUSH spans cycles 1..ROWS+COLS−1 and the first out_valid is asserted at cycle ROWS+COLS.
- Minimum total latency, with in_valid and out_ready held high: start to done = 1 + k_len + (ROWS+COLS−1) + ROWS + 1 cycles.
- done and busy=0 appear in the same cycle; a new start is accepted in that cycle.

## Test plan
- Identity, ROWS=COLS=4, k_len=4, offset 0, ifmap = identity rows, weight = B where B[k][c] = k*4+c, backpressure-free -> row r of out_data equals row r of B; first out_valid exactly 8 cycles after the last accept.
- Offset cancel: offset=128, every ifmap=−128, weight=127, k_len=10 -> all 16 outputs 0.
- Worst case: ifmap=127, offset=255, weight=−128, k_len=3 -> every output = 3×382×(−128) = −146688.
- Stalls: same data as the identity case with in_valid toggled 1,0,0,1… and out_ready low for 3 cycles per drain beat -> identical results; out_data stable throughout each stall.
- Accumulate mode: run k_len=2, then start with accumulate=1 and k_len=2 -> result equals a single k_len=4 run; with accumulate=0 -> result equals the second run only.
- Reset mid-FEED after 2 beats -> all outputs 0, busy=0 immediately; the next full run produces correct results.
